// File: rtl/soml_pkg.sv
// Shared constants and types for the SOML metric controller and its min tracker.
package soml_pkg;
  localparam int DW    = 16;
  localparam int LANES = 4;
  localparam int NRES  = 2;
  localparam int LAT   = 3;
  localparam int FRAME = 16;
  localparam int IDXW  = 4;
  localparam int FRAC  = 8;
  localparam int CW    = $clog2(NRES + LAT);
  localparam int WI    = (NRES > 1) ? $clog2(NRES) : 1;

  localparam logic [DW-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DW-1:0] SAT_MIN = 16'h8000;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  typedef struct packed {
    logic [DW*LANES-1:0] c0r;
    logic [DW*LANES-1:0] c0i;
    logic [DW*LANES-1:0] c1r;
    logic [DW*LANES-1:0] c1i;
  } cand_t;
endpackage

// File: rtl/soml_min_track.sv
// Saturating per-candidate metric sum, running frame minimum and candidate index.
module soml_min_track import soml_pkg::*; (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     upd,
  input  logic [NRES-1:0][DW-1:0]  words,
  output logic [IDXW-1:0]          idx,
  output logic                     frame_done,
  output logic [DW-1:0]            min_val,
  output logic [IDXW-1:0]          min_idx
);
  localparam int SW = DW + $clog2(NRES) + 1;
  localparam logic signed [SW-1:0] HI = SW'(32'sd32767);
  localparam logic signed [SW-1:0] LO = SW'(-32'sd32768);

  logic signed [SW-1:0] acc;
  logic [DW-1:0]        sum;
  logic                 last;

  always_comb begin
    acc = '0;
    for (int k = 0; k < NRES; k++) acc = acc + SW'($signed(words[k]));
    if (acc > HI)      sum = SAT_MAX;
    else if (acc < LO) sum = SAT_MIN;
    else               sum = acc[DW-1:0];
  end

  assign last = (idx == IDXW'(FRAME-1));

  // Index holds at FRAME-1 through the frame_done cycle so min_idx stays meaningful there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx        <= '0;
      frame_done <= 1'b0;
      min_val    <= SAT_MAX;
      min_idx    <= '0;
    end else begin
      frame_done <= upd && last;
      if (frame_done) begin
        min_val <= SAT_MAX;
        min_idx <= '0;
        idx     <= '0;
      end else if (upd) begin
        if ($signed(sum) < $signed(min_val)) begin
          min_val <= sum;
          min_idx <= idx;
        end
        if (!last) idx <= idx + 1'b1;
      end
    end
  end
endmodule

// File: rtl/soml_metric_ctrl.sv
// Candidate feeder / result collector for the SOML Y-projection metric datapath.
module soml_metric_ctrl import soml_pkg::*; (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW*LANES-1:0]  in_col0_r,
  input  logic [DW*LANES-1:0]  in_col0_i,
  input  logic [DW*LANES-1:0]  in_col1_r,
  input  logic [DW*LANES-1:0]  in_col1_i,
  output logic                 dp_start,
  output logic [DW*LANES-1:0]  dp_col0_r,
  output logic [DW*LANES-1:0]  dp_col0_i,
  output logic [DW*LANES-1:0]  dp_col1_r,
  output logic [DW*LANES-1:0]  dp_col1_i,
  input  logic [DW-1:0]        dp_out_r,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [NRES*DW-1:0]   res_data,
  output logic [IDXW-1:0]      res_idx,
  output logic                 frame_done,
  output logic [DW-1:0]        min_val,
  output logic [IDXW-1:0]      min_idx
);
  logic [1:0]               state;
  logic [CW-1:0]            cnt;
  cand_t                    col;
  logic [NRES-1:0][DW-1:0]  res_w;
  logic [WI-1:0]            widx;

  assign in_ready  = (state == IDLE);
  assign res_valid = (state == HOLD);
  // Exactly NRES start cycles per candidate keep the datapath phase sequencer aligned.
  assign dp_start  = (state == RUN) && (cnt < CW'(NRES));
  assign widx      = WI'(cnt - CW'(LAT));

  assign dp_col0_r = col.c0r;
  assign dp_col0_i = col.c0i;
  assign dp_col1_r = col.c1r;
  assign dp_col1_i = col.c1i;
  assign res_data  = res_w;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      col   <= '0;
      res_w <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          col   <= '{c0r: in_col0_r, c0i: in_col0_i, c1r: in_col1_r, c1i: in_col1_i};
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt >= CW'(LAT)) res_w[widx] <= dp_out_r;
          if (cnt == CW'(NRES+LAT-1)) state <= HOLD;
        end
        HOLD: if (res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  soml_min_track u_min (
    .clk        (clk),
    .rst        (rst),
    .upd        (res_valid && res_ready),
    .words      (res_w),
    .idx        (res_idx),
    .frame_done (frame_done),
    .min_val    (min_val),
    .min_idx    (min_idx)
  );
endmodule

// File: tb/tb_soml_metric_ctrl.sv
// Scoreboard bench for soml_metric_ctrl with a latency-LAT datapath stub.
module tb_soml_metric_ctrl;
  import soml_pkg::*;
  localparam int BW = DW*LANES;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic            in_valid = 1'b0, in_ready;
  logic [BW-1:0]   in_col0_r = '0, in_col0_i = '0, in_col1_r = '0, in_col1_i = '0;
  logic            dp_start;
  logic [BW-1:0]   dp_col0_r, dp_col0_i, dp_col1_r, dp_col1_i;
  logic [DW-1:0]   dp_out_r;
  logic            res_valid, res_ready = 1'b1;
  logic [NRES*DW-1:0] res_data;
  logic [IDXW-1:0] res_idx, min_idx;
  logic            frame_done;
  logic [DW-1:0]   min_val;

  soml_metric_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_col0_r(in_col0_r), .in_col0_i(in_col0_i), .in_col1_r(in_col1_r), .in_col1_i(in_col1_i),
    .dp_start(dp_start), .dp_col0_r(dp_col0_r), .dp_col0_i(dp_col0_i),
    .dp_col1_r(dp_col1_r), .dp_col1_i(dp_col1_i), .dp_out_r(dp_out_r),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx),
    .frame_done(frame_done), .min_val(min_val), .min_idx(min_idx)
  );

  // Datapath stub: phase toggles per start cycle, result appears LAT cycles later.
  logic [DW-1:0]  w0 = '0, w1 = '0;
  logic [LAT-1:0] sv, sp;
  logic           ph;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sv <= '0; sp <= '0; ph <= 1'b0;
    end else begin
      sv <= {sv[LAT-2:0], dp_start};
      sp <= {sp[LAT-2:0], ph};
      if (dp_start) ph <= ~ph;
    end
  end
  assign dp_out_r = sv[LAT-1] ? (sp[LAT-1] ? w1 : w0) : 16'hDEAD;

  int errs = 0, checks = 0;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  typedef struct { logic [NRES*DW-1:0] data; logic [IDXW-1:0] idx; } exp_t;
  exp_t q[$];
  exp_t e;
  int m_min = 32767, m_idx = 0, m_cnt = 0;
  logic [DW-1:0]   fin_min = '0;
  logic [IDXW-1:0] fin_idx = '0;
  int fd_cnt = 0, dp_cnt = 0;

  task automatic model_reset();
    q.delete();
    m_min = 32767; m_idx = 0; m_cnt = 0;
  endtask

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    q.push_back('{data: {b, a}, idx: IDXW'(m_cnt)});
    if (s < m_min) begin m_min = s; m_idx = m_cnt; end
    if (m_cnt == FRAME-1) begin
      fin_min = DW'(m_min); fin_idx = IDXW'(m_idx);
      m_min = 32767; m_idx = 0; m_cnt = 0;
    end else m_cnt++;
  endtask

  always @(negedge clk) begin
    if (!rst) dp_cnt = 0;
    else begin
      if (dp_start) dp_cnt++;
      if (res_valid && res_ready) begin
        chk("res_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("res_data", res_data, e.data);
          chk("res_idx", res_idx, e.idx);
          chk("dp_start_cycles", dp_cnt, NRES);
        end
        dp_cnt = 0;
      end
      if (frame_done) begin
        fd_cnt++;
        chk("min_val_final", min_val, fin_min);
        chk("min_idx_final", min_idx, fin_idx);
      end
    end
  end

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [BW-1:0] c);
    int n;
    w0 = a; w1 = b;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_col0_r = c; in_col0_i = ~c; in_col1_r = {c[BW/2-1:0], c[BW-1:BW/2]}; in_col1_i = c + 1'b1;
    push(a, b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_col0_r = {$urandom, $urandom}; in_col0_i = {$urandom, $urandom};
    in_col1_r = {$urandom, $urandom}; in_col1_i = {$urandom, $urandom};
    chk("dp_col0_r", dp_col0_r, c);
    chk("dp_col0_i", dp_col0_i, ~c);
    chk("dp_col1_i", dp_col1_i, c + 1'b1);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("res_timeout", q.size(), 0);
  endtask

  task automatic rst_chk();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_dp_start", dp_start, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_min_val", min_val, 16'h7FFF);
    chk("rst_min_idx", min_idx, 0);
    chk("rst_res_idx", res_idx, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_dp_col0_r", dp_col0_r, 0);
    chk("rst_dp_col1_i", dp_col1_i, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [NRES*DW-1:0] held;
    int n;
    repeat (2) @(posedge clk);
    #1 rst_chk();
    rst = 1'b1;
    @(posedge clk); #1;

    // single candidate
    send(16'h0100, 16'h0080, 64'h0123_4567_89AB_CDEF);
    wait_empty();
    chk("min_single", min_val, 16'h0180);

    // back-pressure: result held, new candidates dropped
    res_ready = 1'b0;
    send(16'h0300, 16'h0000, 64'h1111_2222_3333_4444);
    n = 0;
    while (!res_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_res_valid_seen", res_valid, 1);
    held = {16'h0000, 16'h0300};
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      @(posedge clk); #1;
      chk("bp_res_valid", res_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_res_data", res_data, held);
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    wait_empty();
    repeat (3) @(posedge clk); #1;
    chk("bp_no_queued", res_valid | dp_start, 0);
    chk("bp_idle", in_ready, 1);

    // saturation
    send(16'h7F00, 16'h7F00, 64'hAAAA_5555_AAAA_5555);
    wait_empty();
    chk("sat_hi_not_min", min_val, 16'h0180);
    send(16'h8100, 16'h8100, 64'h5555_AAAA_5555_AAAA);
    wait_empty();
    chk("sat_lo_min_val", min_val, 16'h8000);
    chk("sat_lo_min_idx", min_idx, 3);

    // reset during RUN at cnt=1
    w0 = 16'h0100; w1 = 16'h0080;
    in_valid = 1'b1; in_col0_r = 64'hFFFF_0000_FFFF_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("run_dp_start", dp_start, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1 rst_chk();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    send(16'h0100, 16'h0080, 64'h0F0F_F0F0_0F0F_F0F0);
    wait_empty();

    // full frame from a clean start
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < FRAME; i++) begin
      if (i == 3 || i == 9) send(16'h0100, 16'h0100, {32'(i), 32'hC0DE_0000});
      else                  send(16'h0200, DW'(16*i + 16), {32'(i), 32'hBEEF_0000});
      wait_empty();
    end
    chk("frame_done_pulse", frame_done, 1);
    @(posedge clk); #1;
    chk("frame_done_low", frame_done, 0);
    chk("frame_min_reset", min_val, 16'h7FFF);
    chk("frame_idx_reset", min_idx, 0);
    chk("frame_res_idx_wrap", res_idx, 0);
    chk("frame_done_count", fd_cnt, 1);
    send(16'h0040, 16'h0040, 64'h7777_8888_9999_AAAA);
    wait_empty();
    chk("next_frame_min", min_val, 16'h0080);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
